output_agc: RTL and testbench

Gain-control and saturation stage between the harmonic-summing state machine and the DAC output module. It accepts the two accumulated channel totals (even and odd harmonics) on the same strobe that currently triggers the DAC send. It scales each total by a shared gain using one serial multiplier, saturates to 16-bit signed, and adapts the gain sample-by-sample so the output stays below a peak threshold. The results feed the DAC output module with a one-cycle valid strobe.

---
 rtl/output_agc_pkg.sv | 28 ++
 rtl/output_agc_serial_mult.sv | 68 ++++++
 rtl/output_agc.sv | 207 ++++++++++++++++++++
 tb/tb_output_agc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_agc_pkg.sv
// Shared definitions for the output gain-control stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package output_agc_pkg;

    localparam int GAIN_FRAC_BITS = 14;
    localparam int GAIN_UNITY     = 16384;

    typedef enum logic [2:0] {
        IDLE,
        MUL_L,
        MUL_R,
        SAT,
        UPDATE
    } state_t;

    // Clamp a signed value into the range of a w-bit two's-complement word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/output_agc_serial_mult.sv
// Serial signed x unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: loads on i_Start, then B_W step edges; o_Done flags the cycle before the final step edge.
// Backpressure: none; a new i_Start reloads the operands even while a product is in flight.
module output_agc_serial_mult #(
    parameter int A_W = 32,
    parameter int B_W = 16,
    parameter int P_W = A_W + B_W
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic signed [A_W-1:0] i_A,
    input  logic        [B_W-1:0] i_B,
    output logic                  o_Done,
    output logic signed [P_W-1:0] o_Product
);
    localparam int CNT_W = $clog2(B_W + 1);

    logic signed [P_W-1:0] mcand_q, mcand_d;
    logic        [B_W-1:0] mplier_q, mplier_d;
    logic signed [P_W-1:0] acc_q, acc_d, acc_step;
    logic      [CNT_W-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    // One shift-add step per cycle; o_Product is the sum being committed on the final step edge,
    // so the caller can capture it and restart the multiplier on that same edge.
    always_comb begin
        acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
        o_Done    = busy_q && (cnt_q == CNT_W'(B_W - 1));
        o_Product = acc_step;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        if (i_Start) begin
            mcand_d  = {{(P_W - A_W){i_A[A_W-1]}}, i_A};
            mplier_d = i_B;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !o_Done;
        end
    end

    // Multiplier state registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/output_agc.sv
// Scales L/R accumulator totals by an adaptive shared gain, saturates to OUT_WIDTH and strobes o_Valid.
// Latency: fixed 35 cycles from the i_Start edge to the o_Valid cycle.
// Backpressure: none; i_Start while a sample is in flight is dropped and flagged on o_Overrun.
module output_agc
    import output_agc_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 16,
    parameter int GAIN_BITS    = 16,
    parameter int PRE_SHIFT    = 6,
    parameter int THRESHOLD    = 28000,
    parameter int ATTACK_SHIFT = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Start,
    input  logic signed [IN_WIDTH-1:0]  i_Sample_L,
    input  logic signed [IN_WIDTH-1:0]  i_Sample_R,
    input  logic                        i_AGC_Enable,
    input  logic        [GAIN_BITS-1:0] i_Gain_Max,
    output logic signed [OUT_WIDTH-1:0] o_Sample_L,
    output logic signed [OUT_WIDTH-1:0] o_Sample_R,
    output logic                        o_Valid,
    output logic                        o_Busy,
    output logic                        o_Clipped,
    output logic                        o_Overrun,
    output logic        [GAIN_BITS-1:0] o_Gain
);
    localparam int P_W = IN_WIDTH + GAIN_BITS;

    state_t                      state_q, state_d;
    logic signed [IN_WIDTH-1:0]  sample_r_q, sample_r_d;
    logic signed [P_W-1:0]       prod_l_q, prod_l_d, prod_r_q, prod_r_d;
    logic signed [OUT_WIDTH-1:0] sat_l_q, sat_l_d, sat_r_q, sat_r_d;
    logic signed [OUT_WIDTH-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
    logic                        clip_q, clip_d, over_q, over_d;
    logic                        valid_q, valid_d, busy_q, busy_d;
    logic                        clipped_q, clipped_d, overrun_q, overrun_d;
    logic        [GAIN_BITS-1:0] gain_q, gain_d;

    logic                        mul_start, mul_done;
    logic signed [IN_WIDTH-1:0]  mul_a;
    logic signed [P_W-1:0]       mul_prod;

    logic signed [P_W-1:0]       y_l, y_r;
    logic        [P_W-1:0]       mag_l, mag_r;
    logic signed [63:0]          wide_l, wide_r, lim_l, lim_r;

    logic        [GAIN_BITS-1:0] cmax, dec, gain_next;
    logic        [GAIN_BITS:0]   inc;

    output_agc_serial_mult #(
        .A_W (IN_WIDTH),
        .B_W (GAIN_BITS),
        .P_W (P_W)
    ) u_serial_mult (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_Start   (mul_start),
        .i_A       (mul_a),
        .i_B       (gain_q),
        .o_Done    (mul_done),
        .o_Product (mul_prod)
    );

    // L is fed straight from the port on accept; R is restarted on the edge L completes.
    always_comb begin
        mul_start = 1'b0;
        mul_a     = sample_r_q >>> PRE_SHIFT;
        if (state_q == IDLE) begin
            mul_start = i_Start;
            mul_a     = i_Sample_L >>> PRE_SHIFT;
        end else if (state_q == MUL_L) begin
            mul_start = mul_done;
        end
    end

    // Drop the gain fraction, clamp each channel and take magnitudes for the peak detector.
    always_comb begin
        y_l    = prod_l_q >>> GAIN_FRAC_BITS;
        y_r    = prod_r_q >>> GAIN_FRAC_BITS;
        mag_l  = y_l[P_W-1] ? $unsigned(-y_l) : $unsigned(y_l);
        mag_r  = y_r[P_W-1] ? $unsigned(-y_r) : $unsigned(y_r);
        wide_l = 64'(y_l);
        wide_r = 64'(y_r);
        lim_l  = saturate(wide_l, OUT_WIDTH);
        lim_r  = saturate(wide_r, OUT_WIDTH);
    end

    // Next gain: attack by G>>ATTACK_SHIFT when over threshold, else release by one, capped at Cmax.
    always_comb begin
        cmax = (i_Gain_Max == '0) ? GAIN_BITS'(1) : i_Gain_Max;
        dec  = gain_q >> ATTACK_SHIFT;
        inc  = {1'b0, gain_q} + 1'b1;
        if (!i_AGC_Enable) begin
            gain_next = cmax;
        end else if (over_q) begin
            gain_next = gain_q - dec;
        end else if (inc > {1'b0, cmax}) begin
            gain_next = cmax;
        end else begin
            gain_next = inc[GAIN_BITS-1:0];
        end
        if (gain_next > cmax) gain_next = cmax;
    end

    // Sequencer: accept, two time-shared multiplies, saturate, then publish and adapt gain.
    always_comb begin
        state_d    = state_q;
        sample_r_d = sample_r_q;
        prod_l_d   = prod_l_q;
        prod_r_d   = prod_r_q;
        sat_l_d    = sat_l_q;
        sat_r_d    = sat_r_q;
        clip_d     = clip_q;
        over_d     = over_q;
        out_l_d    = out_l_q;
        out_r_d    = out_r_q;
        clipped_d  = clipped_q;
        gain_d     = gain_q;
        valid_d    = 1'b0;
        overrun_d  = i_Start && (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (i_Start) begin
                    sample_r_d = i_Sample_R;
                    state_d    = MUL_L;
                end
            end
            MUL_L: begin
                if (mul_done) begin
                    prod_l_d = mul_prod;
                    state_d  = MUL_R;
                end
            end
            MUL_R: begin
                if (mul_done) begin
                    prod_r_d = mul_prod;
                    state_d  = SAT;
                end
            end
            SAT: begin
                sat_l_d = lim_l[OUT_WIDTH-1:0];
                sat_r_d = lim_r[OUT_WIDTH-1:0];
                clip_d  = (lim_l != wide_l) || (lim_r != wide_r);
                over_d  = ((mag_l > mag_r) ? mag_l : mag_r) > P_W'(THRESHOLD);
                state_d = UPDATE;
            end
            UPDATE: begin
                out_l_d   = sat_l_q;
                out_r_d   = sat_r_q;
                clipped_d = clip_q;
                valid_d   = 1'b1;
                gain_d    = gain_next;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || valid_d;
    end

    // State and output registers; reset aborts any in-flight sample.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            sample_r_q <= '0;
            prod_l_q   <= '0;
            prod_r_q   <= '0;
            sat_l_q    <= '0;
            sat_r_q    <= '0;
            clip_q     <= 1'b0;
            over_q     <= 1'b0;
            out_l_q    <= '0;
            out_r_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            clipped_q  <= 1'b0;
            overrun_q  <= 1'b0;
            gain_q     <= GAIN_BITS'(GAIN_UNITY);
        end else begin
            state_q    <= state_d;
            sample_r_q <= sample_r_d;
            prod_l_q   <= prod_l_d;
            prod_r_q   <= prod_r_d;
            sat_l_q    <= sat_l_d;
            sat_r_q    <= sat_r_d;
            clip_q     <= clip_d;
            over_q     <= over_d;
            out_l_q    <= out_l_d;
            out_r_q    <= out_r_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            clipped_q  <= clipped_d;
            overrun_q  <= overrun_d;
            gain_q     <= gain_d;
        end
    end

    assign o_Sample_L = out_l_q;
    assign o_Sample_R = out_r_q;
    assign o_Valid    = valid_q;
    assign o_Busy     = busy_q;
    assign o_Clipped  = clipped_q;
    assign o_Overrun  = overrun_q;
    assign o_Gain     = gain_q;

endmodule

// File: tb/tb_output_agc.sv
// Bench for output_agc: directed scenarios plus randomized samples against an arithmetic model.
// Latency: checks the fixed 35-cycle i_Start to o_Valid delay on every sample.
// Backpressure: exercises overrun, back-to-back issue and mid-computation reset.
module tb_output_agc;

    logic               i_Clock = 1'b0;
    logic               i_Reset = 1'b1;
    logic               i_Start = 1'b0;
    logic signed [31:0] i_Sample_L = '0;
    logic signed [31:0] i_Sample_R = '0;
    logic               i_AGC_Enable = 1'b0;
    logic        [15:0] i_Gain_Max = 16'd16384;
    logic signed [15:0] o_Sample_L;
    logic signed [15:0] o_Sample_R;
    logic               o_Valid;
    logic               o_Busy;
    logic               o_Clipped;
    logic               o_Overrun;
    logic        [15:0] o_Gain;

    int vectors = 0;
    int miscompares = 0;
    int model_g = 16384;

    always #10 i_Clock = ~i_Clock;

    output_agc dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Start      (i_Start),
        .i_Sample_L   (i_Sample_L),
        .i_Sample_R   (i_Sample_R),
        .i_AGC_Enable (i_AGC_Enable),
        .i_Gain_Max   (i_Gain_Max),
        .o_Sample_L   (o_Sample_L),
        .o_Sample_R   (o_Sample_R),
        .o_Valid      (o_Valid),
        .o_Busy       (o_Busy),
        .o_Clipped    (o_Clipped),
        .o_Overrun    (o_Overrun),
        .o_Gain       (o_Gain)
    );

    function automatic int clamp16(input longint y);
        if (y > 32767) return 32767;
        if (y < -32768) return -32768;
        return int'(y);
    endfunction

    // Reference: y = floor((s/64) * G / 16384), clamp, then adapt gain from the pre-clamp peak.
    function automatic void model_step(input int l, input int r, input bit agc, input int gmax,
                                       output int el, output int er, output bit ec);
        longint yl, yr, al, ar, pk;
        int cmax;
        yl = ((longint'(l) >>> 6) * longint'(model_g)) >>> 14;
        yr = ((longint'(r) >>> 6) * longint'(model_g)) >>> 14;
        el = clamp16(yl);
        er = clamp16(yr);
        ec = (longint'(el) != yl) || (longint'(er) != yr);
        al = (yl < 0) ? -yl : yl;
        ar = (yr < 0) ? -yr : yr;
        pk = (al > ar) ? al : ar;
        cmax = (gmax == 0) ? 1 : gmax;
        if (!agc) model_g = cmax;
        else if (pk > 28000) model_g = model_g - (model_g >> 4);
        else model_g = (model_g + 1 < cmax) ? model_g + 1 : cmax;
        if (model_g > cmax) model_g = cmax;
    endfunction

    // Drives one i_Start from a negedge and returns at the negedge where o_Valid is seen (or times out).
    task automatic do_sample(input int l, input int r, input bit agc, input int gmax, output int lat);
        i_Sample_L   = l;
        i_Sample_R   = r;
        i_AGC_Enable = agc;
        i_Gain_Max   = 16'(gmax);
        i_Start      = 1'b1;
        @(negedge i_Clock);
        i_Start = 1'b0;
        lat = 1;
        while (!o_Valid && lat < 100) begin
            @(negedge i_Clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        i_Start = 1'b0;
        repeat (3) @(negedge i_Clock);
        vectors++; if (o_Sample_L !== 16'sd0) begin miscompares++; $display("FAIL reset_L: got %0d expected 0", o_Sample_L); end
        vectors++; if (o_Sample_R !== 16'sd0) begin miscompares++; $display("FAIL reset_R: got %0d expected 0", o_Sample_R); end
        vectors++; if (o_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", o_Valid); end
        vectors++; if (o_Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
        vectors++; if (o_Clipped !== 1'b0) begin miscompares++; $display("FAIL reset_clip: got %b expected 0", o_Clipped); end
        vectors++; if (o_Overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", o_Overrun); end
        vectors++; if (o_Gain !== 16'd16384) begin miscompares++; $display("FAIL reset_gain: got %0d expected 16384", o_Gain); end
        i_Reset = 1'b0;
        model_g = 16384;
        @(negedge i_Clock);
    endtask

    task automatic test_unity();
        int lat, el, er;
        bit ec;
        do_sample(64000, -64, 1'b0, 16384, lat);
        model_step(64000, -64, 1'b0, 16384, el, er, ec);
        vectors++; if (lat !== 35) begin miscompares++; $display("FAIL unity_latency: got %0d expected 35", lat); end
        vectors++; if (o_Sample_L !== 16'sd1000 || o_Sample_R !== -16'sd1 || o_Clipped !== 1'b0) begin
            miscompares++; $display("FAIL unity_out: got L=%0d R=%0d clip=%b expected L=1000 R=-1 clip=0", o_Sample_L, o_Sample_R, o_Clipped); end
        vectors++; if (o_Busy !== 1'b1 || int'(o_Gain) !== model_g) begin
            miscompares++; $display("FAIL unity_busy_gain: got busy=%b gain=%0d expected busy=1 gain=%0d", o_Busy, o_Gain, model_g); end
        @(negedge i_Clock);
        vectors++; if (o_Valid !== 1'b0 || o_Busy !== 1'b0) begin
            miscompares++; $display("FAIL unity_pulse: got valid=%b busy=%b expected 0 0", o_Valid, o_Busy); end
    endtask

    task automatic test_saturation();
        int lat, el, er;
        bit ec;
        do_sample(32'sd1 <<< 30, -(32'sd1 <<< 30), 1'b0, 16384, lat);
        model_step(32'sd1 <<< 30, -(32'sd1 <<< 30), 1'b0, 16384, el, er, ec);
        vectors++; if (lat !== 35 || o_Sample_L !== 16'sd32767 || o_Sample_R !== -16'sd32768 || o_Clipped !== 1'b1) begin
            miscompares++; $display("FAIL sat_out: got lat=%0d L=%0d R=%0d clip=%b expected 35 32767 -32768 1", lat, o_Sample_L, o_Sample_R, o_Clipped); end
        repeat (5) @(negedge i_Clock);
        vectors++; if (o_Clipped !== 1'b1 || o_Sample_L !== 16'sd32767) begin
            miscompares++; $display("FAIL sat_hold: got clip=%b L=%0d expected 1 32767", o_Clipped, o_Sample_L); end
    endtask

    task automatic test_attack();
        int lat, el, er;
        bit ec;
        do_sample(1920000, 0, 1'b1, 16384, lat);
        model_step(1920000, 0, 1'b1, 16384, el, er, ec);
        vectors++; if (lat !== 35 || o_Sample_L !== 16'sd30000 || o_Sample_R !== 16'sd0 || o_Clipped !== 1'b0) begin
            miscompares++; $display("FAIL attack_out: got lat=%0d L=%0d R=%0d clip=%b expected 35 30000 0 0", lat, o_Sample_L, o_Sample_R, o_Clipped); end
        vectors++; if (o_Gain !== 16'd15360 || model_g != 15360) begin
            miscompares++; $display("FAIL attack_gain: got %0d expected 15360 (model %0d)", o_Gain, model_g); end
    endtask

    task automatic test_release();
        int lat, el, er, want;
        bit ec;
        for (int i = 0; i < 7; i++) begin
            do_sample(6400, -640, 1'b1, 15365, lat);
            model_step(6400, -640, 1'b1, 15365, el, er, ec);
            want = (15361 + i < 15365) ? 15361 + i : 15365;
            vectors++; if (lat !== 35 || int'(o_Gain) !== want || int'(o_Sample_L) !== el || int'(o_Sample_R) !== er) begin
                miscompares++; $display("FAIL release_%0d: got lat=%0d gain=%0d L=%0d R=%0d expected 35 %0d %0d %0d",
                                        i, lat, o_Gain, o_Sample_L, o_Sample_R, want, el, er); end
            @(negedge i_Clock);
        end
    endtask

    task automatic test_back_to_back();
        int lat, l, r, el, er;
        bit ec;
        for (int i = 0; i < 4; i++) begin
            l = int'($urandom) >>> 8;
            r = int'($urandom) >>> 8;
            do_sample(l, r, 1'b1, 16384, lat);
            model_step(l, r, 1'b1, 16384, el, er, ec);
            vectors++; if (lat !== 35 || int'(o_Sample_L) !== el || int'(o_Sample_R) !== er || o_Clipped !== ec || int'(o_Gain) !== model_g) begin
                miscompares++; $display("FAIL b2b_%0d: got lat=%0d L=%0d R=%0d clip=%b gain=%0d expected 35 %0d %0d %b %0d",
                                        i, lat, o_Sample_L, o_Sample_R, o_Clipped, o_Gain, el, er, ec, model_g); end
        end
        @(negedge i_Clock);
    endtask

    task automatic test_overrun();
        int lat, ov, el, er;
        bit ec;
        i_Sample_L = 128000; i_Sample_R = -256000; i_AGC_Enable = 1'b0; i_Gain_Max = 16'd16384;
        i_Start = 1'b1;
        @(negedge i_Clock);
        i_Start = 1'b0;
        lat = 1;
        ov = 0;
        while (!o_Valid && lat < 100) begin
            i_Start = (lat == 10);
            if (lat == 10) begin i_Sample_L = 999999; i_Sample_R = 777777; end
            @(negedge i_Clock);
            lat++;
            if (o_Overrun) ov++;
        end
        i_Start = 1'b0;
        model_step(128000, -256000, 1'b0, 16384, el, er, ec);
        vectors++; if (ov !== 1) begin miscompares++; $display("FAIL overrun_count: got %0d expected 1", ov); end
        vectors++; if (lat !== 35 || int'(o_Sample_L) !== el || int'(o_Sample_R) !== er) begin
            miscompares++; $display("FAIL overrun_out: got lat=%0d L=%0d R=%0d expected 35 %0d %0d", lat, o_Sample_L, o_Sample_R, el, er); end
        @(negedge i_Clock);
    endtask

    task automatic test_reset_mid();
        int lat, nv, el, er;
        bit ec;
        i_Sample_L = 640000; i_Sample_R = 64000; i_AGC_Enable = 1'b1; i_Gain_Max = 16'd20000;
        i_Start = 1'b1;
        @(negedge i_Clock);
        i_Start = 1'b0;
        repeat (19) @(negedge i_Clock);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        vectors++; if (o_Sample_L !== 16'sd0 || o_Sample_R !== 16'sd0 || o_Gain !== 16'd16384 || o_Busy !== 1'b0 || o_Clipped !== 1'b0) begin
            miscompares++; $display("FAIL midreset_state: got L=%0d R=%0d gain=%0d busy=%b clip=%b expected 0 0 16384 0 0",
                                    o_Sample_L, o_Sample_R, o_Gain, o_Busy, o_Clipped); end
        model_g = 16384;
        // Reset and start on the same edge: reset must win.
        i_Reset = 1'b1;
        i_Start = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        i_Start = 1'b0;
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_Clock);
            if (o_Valid || o_Busy) nv++;
        end
        vectors++; if (nv !== 0) begin miscompares++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", nv); end
        do_sample(640000, 64000, 1'b1, 20000, lat);
        model_step(640000, 64000, 1'b1, 20000, el, er, ec);
        vectors++; if (lat !== 35 || int'(o_Sample_L) !== el || int'(o_Sample_R) !== er || int'(o_Gain) !== model_g) begin
            miscompares++; $display("FAIL midreset_next: got lat=%0d L=%0d R=%0d gain=%0d expected 35 %0d %0d %0d",
                                    lat, o_Sample_L, o_Sample_R, o_Gain, el, er, model_g); end
        @(negedge i_Clock);
    endtask

    task automatic test_random();
        int lat, l, r, gmax, el, er;
        bit agc, ec;
        for (int i = 0; i < 24; i++) begin
            l = int'($urandom) >>> $urandom_range(4, 14);
            r = int'($urandom) >>> $urandom_range(4, 14);
            agc = 1'($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: gmax = 0;
                1: gmax = 16384;
                2: gmax = 20000;
                default: gmax = int'($urandom_range(1, 65535));
            endcase
            do_sample(l, r, agc, gmax, lat);
            model_step(l, r, agc, gmax, el, er, ec);
            vectors++; if (lat !== 35 || int'(o_Sample_L) !== el || int'(o_Sample_R) !== er || o_Clipped !== ec || int'(o_Gain) !== model_g) begin
                miscompares++; $display("FAIL random_%0d: in L=%0d R=%0d agc=%b gmax=%0d got lat=%0d L=%0d R=%0d clip=%b gain=%0d expected 35 %0d %0d %b %0d",
                                        i, l, r, agc, gmax, lat, o_Sample_L, o_Sample_R, o_Clipped, o_Gain, el, er, ec, model_g); end
            repeat ($urandom_range(1, 4)) @(negedge i_Clock);
        end
    endtask

    initial begin
        @(negedge i_Clock);
        test_reset();
        test_unity();
        test_saturation();
        test_attack();
        test_release();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
